instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded field bundles into machine words with an
// immediate-range error flag, buffered through a 2-entry in-order output FIFO.
//
// state | meaning
// EMPTY | no word buffered, out_valid low
// ONE   | head word valid in out_instr/out_err
// FULL  | head plus one queued word, in_ready low
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_cls,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic        in_f7b5,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic        err_sticky,
    output logic [15:0] enc_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_t;

    fifo_state_t       state;
    logic [31:0]       word;
    logic              err;
    logic [31:0]       slot1_instr;
    logic              slot1_err;
    logic signed [31:0] imm_s;
    logic              is_shift;
    logic              push;
    logic              pop;

    assign imm_s     = $signed(in_imm);
    assign is_shift  = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready & ~clr;
    assign pop       = out_valid & out_ready & ~clr;

    // Errored bundles still produce the truncated word; only the flag marks them.
    always_comb begin
        word = '0;
        err  = 1'b0;
        case (in_cls)
            3'd0: begin
                word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
                err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            3'd1: begin
                word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
                err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            end
            3'd2: begin
                word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            end
            3'd3: begin
                word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
                err  = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
            end
            3'd4: begin
                if (is_shift) begin
                    word = {1'b0, in_f7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3,
                            in_rd, 7'b0010011};
                    err  = (imm_s < 32'sd0) || (imm_s > 32'sd31);
                end else begin
                    word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                    err  = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
                end
            end
            3'd5: begin
                word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                err  = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
            end
            3'd6: begin
                word = {in_imm[31:12], in_rd, 7'b0110111};
                err  = (in_imm[11:0] != 12'd0);
            end
            default: begin
                word = {in_imm[31:12], in_rd, 7'b0010111};
                err  = (in_imm[11:0] != 12'd0);
            end
        endcase
    end

    // out_instr/out_err are the head slot itself, so they hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            out_instr   <= '0;
            out_err     <= 1'b0;
            slot1_instr <= '0;
            slot1_err   <= 1'b0;
            err_sticky  <= 1'b0;
            enc_count   <= '0;
        end else if (clr) begin
            state      <= EMPTY;
            err_sticky <= 1'b0;
            enc_count  <= '0;
        end else begin
            if (push) begin
                enc_count <= enc_count + 16'd1;
                if (err) err_sticky <= 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        out_instr <= word;
                        out_err   <= err;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        out_instr <= word;
                        out_err   <= err;
                    end else if (push) begin
                        slot1_instr <= word;
                        slot1_err   <= err;
                        state       <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        out_instr <= slot1_instr;
                        out_err   <= slot1_err;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized bundles
// compared against a queue-based reference model of encoder, FIFO and counters.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_cls;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_f7b5;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        err_sticky;
    logic [15:0] enc_count;

    instr_encoder dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .err_sticky(err_sticky), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    int          ncomp = 0;
    int          nfail = 0;
    logic [32:0] q[$];
    logic [15:0] m_cnt;
    logic        m_sticky;

    // Reference encoder built from per-format bit arithmetic and integer range checks.
    function automatic logic [32:0] ref_enc(input logic [31:0] cls, rd, rs1, rs2, f3, f7,
                                            input logic [31:0] imm);
        logic [31:0] opc[8];
        logic [31:0] w;
        logic        e;
        int          si;
        opc = '{32'd3, 32'd35, 32'd51, 32'd99, 32'd19, 32'd111, 32'd55, 32'd23};
        si  = $signed(imm);
        w   = opc[cls[2:0]];
        e   = 1'b0;
        if (cls == 4 && (f3 == 1 || f3 == 5)) begin
            w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 31) << 20) | (f7 << 30);
            e = (si < 0) || (si > 31);
        end else if (cls == 0 || cls == 4) begin
            w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((imm & 32'hfff) << 20);
            e = (si < -2048) || (si > 2047);
        end else if (cls == 1) begin
            w = w | ((imm & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                  | (((imm >> 5) & 127) << 25);
            e = (si < -2048) || (si > 2047);
        end else if (cls == 2) begin
            w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 30);
        end else if (cls == 3) begin
            w = w | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (f3 << 12)
                  | (rs1 << 15) | (rs2 << 20) | (((imm >> 5) & 63) << 25)
                  | (((imm >> 12) & 1) << 31);
            e = (si < -4096) || (si > 4094) || ((imm & 1) != 0);
        end else if (cls == 5) begin
            w = w | (rd << 7) | (((imm >> 12) & 255) << 12) | (((imm >> 11) & 1) << 20)
                  | (((imm >> 1) & 1023) << 21) | (((imm >> 20) & 1) << 31);
            e = (si < -1048576) || (si > 1048574) || ((imm & 1) != 0);
        end else begin
            w = w | (rd << 7) | (imm & 32'hfffff000);
            e = (imm & 32'hfff) != 0;
        end
        return {e, w};
    endfunction

    function automatic logic [32:0] cur_enc();
        return ref_enc(32'(in_cls), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                       32'(in_funct3), 32'(in_f7b5), in_imm);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        check("enc_count", 32'(enc_count), 32'(m_cnt));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        if (q.size() > 0) begin
            check("out_instr", out_instr, q[0][31:0]);
            check("out_err", 32'(out_err), 32'(q[0][32]));
        end
    endtask

    // Inputs are set between negedges; model follows the posedge; outputs read at negedge.
    task automatic step(input bit chk);
        bit          push, pop;
        logic [32:0] ent;
        push = in_valid && (q.size() < 2) && !clr;
        pop  = (q.size() > 0) && out_ready && !clr;
        ent  = cur_enc();
        @(posedge clk);
        if (clr) begin
            q.delete();
            m_cnt    = 16'd0;
            m_sticky = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(ent);
                m_cnt = m_cnt + 16'd1;
                if (ent[32]) m_sticky = 1'b1;
            end
        end
        @(negedge clk);
        if (chk) check_all();
    endtask

    task automatic set_b(input logic [2:0] cls, input logic [4:0] rd, rs1, rs2,
                         input logic [2:0] f3, input logic f7, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_cls    = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_f7b5   = f7;
        in_imm    = imm;
    endtask

    function automatic logic [31:0] rand_imm();
        int bnd[18];
        bnd = '{-2048, 2047, -2049, 2048, 0, 31, 32, -1, -4096, 4094, 4096, -4098,
                -1048576, 1048574, 1048576, -1048578, 32'h12345000, 4095};
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 40));
            1: return 32'($signed($urandom_range(0, 10000)) - 5000);
            2: return 32'(bnd[$urandom_range(0, 17)]);
            3: return $urandom() & 32'hfffff000;
            default: return $urandom();
        endcase
    endfunction

    logic [32:0] w1, w2, w3;

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_cls = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
        in_f7b5 = 1'b0; in_imm = '0;
        m_cnt = 16'd0; m_sticky = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check_all();
        rst = 1'b0;

        // addi x1, x0, 5
        set_b(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        step(1);
        check("addi_word", out_instr, 32'h00500093);
        check("addi_err", 32'(out_err), 32'd0);
        check("addi_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        step(1);

        // sw x2, 8(x3)
        set_b(3'd1, 5'd0, 5'd3, 5'd2, 3'b010, 1'b0, 32'd8);
        step(1);
        check("sw_word", out_instr, 32'h0021A423);
        in_valid = 1'b0;
        step(1);

        // lui then odd-offset branch
        clr = 1'b1; step(1); clr = 1'b0;
        set_b(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000);
        step(1);
        check("lui_word", out_instr, 32'h123452B7);
        check("lui_err", 32'(out_err), 32'd0);
        set_b(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3);
        step(1);
        check("br_err", 32'(out_err), 32'd1);
        check("br_sticky", 32'(err_sticky), 32'd1);
        check("br_count", 32'(enc_count), 32'd2);
        in_valid = 1'b0;
        step(1);

        // backpressure: three bundles into a 2-deep FIFO
        clr = 1'b1; step(1); clr = 1'b0;
        out_ready = 1'b0;
        set_b(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1); w1 = cur_enc(); step(1);
        set_b(3'd4, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2); w2 = cur_enc(); step(1);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        set_b(3'd4, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3); w3 = cur_enc(); step(1);
        check("bp_held_ready", 32'(in_ready), 32'd0);
        check("bp_head1", out_instr, w1[31:0]);
        out_ready = 1'b1;
        step(1);
        check("bp_head2", out_instr, w2[31:0]);
        step(1);
        check("bp_head3", out_instr, w3[31:0]);
        in_valid = 1'b0;
        step(1);
        check("bp_count", 32'(enc_count), 32'd3);
        check("bp_empty", 32'(out_valid), 32'd0);

        // async reset with FIFO full, held across an edge with a pending bundle
        out_ready = 1'b0;
        set_b(3'd2, 5'd4, 5'd5, 5'd6, 3'd0, 1'b1, 32'd0); step(1);
        set_b(3'd7, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00001000); step(1);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_count", 32'(enc_count), 32'd0);
        check("arst_instr", out_instr, 32'd0);
        q.delete(); m_cnt = 16'd0; m_sticky = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_no_push", 32'(out_valid), 32'd0);
        check("rst_no_count", 32'(enc_count), 32'd0);
        rst = 1'b0;
        step(1);
        check("post_rst_push", 32'(enc_count), 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            clr       = 1'($urandom_range(0, 60) == 0);
            in_cls    = 3'($urandom_range(0, 7));
            in_rd     = 5'($urandom());
            in_rs1    = 5'($urandom());
            in_rs2    = 5'($urandom());
            in_funct3 = 3'($urandom());
            in_f7b5   = 1'($urandom());
            in_imm    = rand_imm();
            step(1);
        end
        clr = 1'b0;

        // counter wrap
        clr = 1'b1; step(1); clr = 1'b0;
        out_ready = 1'b1;
        set_b(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
        for (int i = 0; i < 65534; i++) step(0);
        step(1);
        check("wrap_pre", 32'(enc_count), 32'h0000FFFF);
        step(1);
        check("wrap_post", 32'(enc_count), 32'd0);
        in_valid = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
